// File: rtl/ones_fill_if.sv
// ----------------------------------------------------------------------------
// ones_fill_if
//   Handshake bundle for ones_fill_serial: the request channel (count in) and
//   the serial bit channel (pattern out).
//
//   Parameter:
//     vecWidth   - pattern width; sets the width of in_count.
//   Signals:
//     in_valid   - request present                    (master -> slave)
//     in_ready   - slave idle, can accept a request    (slave  -> master)
//     in_count   - requested number of ones            (master -> slave)
//     ser_valid  - ser_bit is valid                    (slave  -> master)
//     ser_ready  - receiver accepts ser_bit            (master -> slave)
//     ser_bit    - current pattern bit, LSB first      (slave  -> master)
//     ser_last   - marks bit index vecWidth-1          (slave  -> master)
//   Modports:
//     master     - requester / serial receiver side
//     slave      - the ones_fill_serial block
// ----------------------------------------------------------------------------
interface ones_fill_if #(
    parameter int vecWidth = 16
);
    localparam int cntWidth = $clog2(vecWidth) + 1;

    logic                in_valid;
    logic                in_ready;
    logic [cntWidth-1:0] in_count;
    logic                ser_valid;
    logic                ser_ready;
    logic                ser_bit;
    logic                ser_last;

    modport master (
        output in_valid, in_count, ser_ready,
        input  in_ready, ser_valid, ser_bit, ser_last
    );

    modport slave (
        input  in_valid, in_count, ser_ready,
        output in_ready, ser_valid, ser_bit, ser_last
    );
endinterface

// File: rtl/ones_fill_serial.sv
// ----------------------------------------------------------------------------
// ones_fill_serial
//   Accepts a ones count and emits a vecWidth-bit thermometer pattern (count
//   ones in the low positions, zeros above) serially, LSB first. When the
//   serial transfer completes, the same pattern is presented on out_vec
//   together with a one-cycle done pulse.
//
//   Parameter:
//     vecWidth - number of pattern bits (must be >= 2)
//   Ports:
//     clk      - clock, rising edge
//     rst_n    - asynchronous active-low reset
//     bus      - ones_fill_if.slave (request channel + serial bit channel)
//     out_vec  - last completed pattern
//     done     - one-cycle pulse when out_vec updates
//     err      - one-cycle pulse after an out-of-range request
//
//   Build option:
//     ONES_FILL_SAT_EN defined   : in_count > vecWidth is clamped to vecWidth
//                                  at acceptance; err is constant 0.
//     ONES_FILL_SAT_EN undefined : an out-of-range request is accepted, err
//                                  pulses once, and nothing else happens.
// ----------------------------------------------------------------------------
module ones_fill_serial #(
    parameter int vecWidth = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    ones_fill_if.slave          bus,
    output logic [vecWidth-1:0] out_vec,
    output logic                done,
    output logic                err
);
    localparam int cntWidth = $clog2(vecWidth) + 1;
    localparam int idxWidth = $clog2(vecWidth);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [cntWidth-1:0] CNT_MAX  = cntWidth'(vecWidth);
    localparam logic [idxWidth-1:0] IDX_LAST = idxWidth'(vecWidth - 1);

    logic [1:0]          state;
    logic [idxWidth-1:0] idx;
    logic [cntWidth-1:0] cnt_q;
    logic                in_ready_q;
    logic                ser_valid_q;
    logic                ser_bit_q;
    logic                ser_last_q;
    logic [vecWidth-1:0] vec_q;
    logic                done_q;
    logic                err_q;

    logic [idxWidth-1:0] idx_nxt;
    logic [cntWidth-1:0] cnt_acc;
    logic                cnt_bad;

    function automatic logic [vecWidth-1:0] thermo(input logic [cntWidth-1:0] c);
        logic [vecWidth-1:0] v;
        for (int i = 0; i < vecWidth; i++) begin
            v[i] = (cntWidth'(i) < c);
        end
        return v;
    endfunction

    // Count as it will be captured at acceptance, plus the out-of-range flag.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        idx_nxt = idx + idxWidth'(1);
        cnt_acc = bus.in_count;
        cnt_bad = 1'b0;
        if (bus.in_count > CNT_MAX) begin
`ifdef ONES_FILL_SAT_EN
            cnt_acc = CNT_MAX;
`else
            cnt_bad = 1'b1;
`endif
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_last_q  <= 1'b0;
            // NOTE: out_vec is a visible output, so it is reset along with the control state.
            vec_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        if (cnt_bad) begin
                            // Handshake completes but nothing is generated.
                            err_q <= 1'b1;
                        end else begin
                            cnt_q       <= cnt_acc;
                            idx         <= '0;
                            state       <= ST_SHIFT;
                            in_ready_q  <= 1'b0;
                            ser_valid_q <= 1'b1;
                            ser_bit_q   <= (cnt_acc != '0);
                            ser_last_q  <= 1'b0;  // vecWidth >= 2
                        end
                    end
                end
                ST_SHIFT: begin
                    // Without ser_ready the index and presented bit simply hold.
                    if (ser_ready_ok()) begin
                        if (idx == IDX_LAST) begin
                            // done/out_vec become visible during the DONE cycle.
                            state       <= ST_DONE;
                            idx         <= '0;
                            ser_valid_q <= 1'b0;
                            ser_bit_q   <= 1'b0;
                            ser_last_q  <= 1'b0;
                            vec_q       <= thermo(cnt_q);
                            done_q      <= 1'b1;
                        end else begin
                            idx        <= idx_nxt;
                            ser_bit_q  <= ({1'b0, idx_nxt} < cnt_q);
                            ser_last_q <= (idx_nxt == IDX_LAST);
                        end
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    function automatic logic ser_ready_ok();
        return ser_valid_q && bus.ser_ready;
    endfunction

    assign bus.in_ready  = in_ready_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_bit   = ser_bit_q;
    assign bus.ser_last  = ser_last_q;
    assign out_vec       = vec_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: doc/ones_fill_serial.md
# ones_fill_serial

Generator-side counterpart to the team's ones-count logic. It accepts a ones count over a valid/ready handshake and serially emits a `vecWidth`-bit thermometer pattern, LSB first, over a second valid/ready handshake. That pattern has exactly `count` ones in the low positions and zeros above. When the serial transfer completes, it also presents the full pattern as a parallel register. Benches use it to produce known-population vectors for the popcount path, and datapaths use it to build masks.

## Interface
- `vecWidth`, 16, number of pattern bits; must be at least 2.
- `cntWidth`, `$clog2(vecWidth)+1`, derived (localparam); width of a count able to hold 0..`vecWidth`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: block idle and able to accept a request.
- `in_count` input `cntWidth`: requested number of ones.
- `ser_valid` output 1: `ser_bit` is valid.
- `ser_ready` input 1: downstream accepts `ser_bit`.
- `ser_bit` output 1: current pattern bit.
- `ser_last` output 1: marks bit index `vecWidth-1`.
- `out_vec` output `vecWidth`: last completed pattern.
- `done` output 1: one-cycle pulse when `out_vec` updates.
- `err` output 1: one-cycle pulse when a request is out of range (no-SAT build only).

## Operation
- Reset values: `in_ready`=0, `ser_valid`=0, `ser_bit`=0, `ser_last`=0, `out_vec`=0, `done`=0, `err`=0, state=IDLE, bit index=0.
- All outputs are registered.
- FSM states:
  - IDLE: `in_ready`=1. A request is accepted on the edge where `in_valid && in_ready`. The count is captured as `cnt_q`, the index is set to 0, and the FSM moves to SHIFT.
  - SHIFT: `ser_valid`=1, `ser_bit`=(idx < `cnt_q`), `ser_last`=(idx == `vecWidth-1`).
    - A bit transfers on an edge where `ser_valid && ser_ready`. The index then increments.
    - With `ser_ready`=0, the index, `ser_bit` and `ser_last` hold (no bit dropped or repeated).
    - The transfer with `ser_last`=1 moves the FSM to DONE.
  - DONE: lasts one cycle. `out_vec` ← thermometer(`cnt_q`), i.e. bit i = (i < `cnt_q`). `done`=1. Next state is IDLE.
- `in_ready` rises on the edge leaving DONE, so back-to-back requests are spaced `vecWidth`+2 cycles apart at minimum.
- `in_count` is sampled only at acceptance; later changes are ignored.
- `in_count`=0 produces all-zero bits. `in_count`=`vecWidth` produces all-one bits.
- Out-of-range handling (`in_count` > `vecWidth`) depends on the configuration; see Configuration.
- Reset mid-operation: all outputs and state return to their reset values immediately (asynchronous). `out_vec` is cleared. A partially shifted pattern is abandoned and no `done` is produced.

## Timing
- Acceptance edge is T0.
- `ser_valid`=1 and bit 0 are present from T0+1.
- With `ser_ready` held at 1:
  - bit k is presented in cycle T0+1+k;
  - `ser_last` is high in cycle T0+`vecWidth`;
  - `done`=1 and the new `out_vec` appear in cycle T0+`vecWidth`+1;
  - `in_ready`=1 from cycle T0+`vecWidth`+2.
- Each cycle with `ser_ready`=0 during SHIFT adds one cycle to every subsequent event.
- After `rst_n` deasserts, `in_ready` rises on the first rising clock edge.

## Configuration
- Macro: `ONES_FILL_SAT_EN`.
- Defined: `in_count` > `vecWidth` is clamped to `vecWidth` at acceptance. `err` is tied to 0.
- Undefined: an out-of-range request is still accepted (handshake completes). `err` pulses for one cycle in the cycle after acceptance and the FSM stays in IDLE. No serial output and no `done` are produced, and `out_vec` is unchanged.

## Test plan
- Reset, then `in_count`=5 with `ser_ready`=1 (`vecWidth`=16):
  - `ser_bit` sequence is 1,1,1,1,1 followed by eleven 0s;
  - `ser_last` is high on the 16th bit;
  - `done` one cycle later with `out_vec`=16'h001F;
  - `in_ready` is back at T0+18.
- Counts 0 and 16: all-zero bits with `out_vec`=16'h0000, and all-one bits with `out_vec`=16'hFFFF.
- Back-pressure with `in_count`=3 and `ser_ready` toggling 1,0,0,1,...:
  - the receiver collects exactly 16 bits, pattern 0x0007;
  - `ser_bit` and `ser_last` hold stable while `ser_ready`=0.
- `in_count`=20:
  - SAT build: output 16'hFFFF and `err` stays 0;
  - non-SAT build: `err` pulses once, no `ser_valid`, `out_vec` keeps its previous value.
- `in_valid` held high across a transfer with `in_count` changed mid-SHIFT: only the sampled count is emitted, and the next request is accepted exactly at `in_ready` re-assertion.
- Assert `rst_n`=0 during bit 7 of a transfer: all outputs drop to reset values asynchronously, and no `done` follows release.
